hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard scheduler for the 5-stage MIPS core.
- Consumes the per-instruction Wants/Needs flags, source/destination register numbers, RegW and MemR produced by the ID-stage decoder.
- Tracks in-flight writers in EX/MEM/WB and decides, each cycle, whether to stall ID (insert an EX bubble) and where each operand is forwarded from, for both ID-stage and EX-stage consumers.

Parameters:
- STALL_LIMIT, 15: consecutive stall cycles after which the sticky error flag sets.
- SCNT_W, 32: width of the optional stall statistics counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- freeze  in  1  global hold (memory busy); all tracker state holds.
- id_valid  in  1  ID holds a real instruction (decoder inst_en).
- id_rs, id_rt  in  5  ID source registers (Src1/Src2).
- id_rdst  in  5  ID destination register.
- id_regw, id_memr  in  1  ID writes a register / is a load.
- id_wants_rs, id_needs_rs, id_wants_rt, id_needs_rt  in  1  ID reads / must have the operand in ID.
- ex_wants_rs, ex_needs_rs, ex_wants_rt, ex_needs_rt  in  1  ID instruction reads / must have the operand when it reaches EX.
- stall  out  1  hold PC and IF/ID; decoder Stall input.
- fwd_id_rs, fwd_id_rt  out  2  ID operand source: 00 register file, 01 MEM ALU result, 10 WB data.
- fwd_ex_rs, fwd_ex_rt  out  2  EX operand source, same encoding.
- stall_err  out  1  sticky: stall held STALL_LIMIT consecutive cycles.

Behaviour:
- Tracker: three entries (EX, MEM, WB), each holding {valid, rd, regw, memr}. The EX entry also holds {rs, rt, ex_wants_rs, ex_wants_rt}.
- "Writer" = valid & regw & rd != 0. Register 0 never matches anything.
- Advance on posedge when freeze=0:
  - WB<=MEM; MEM<=EX.
  - EX<=ID fields if id_valid & !stall, else EX<=bubble (valid=0).
- freeze=1: every entry and the consecutive-stall counter hold; stall forced 1; forward selects keep their combinational values.
- Stall (combinational, only when id_valid=1), for each operand X in {rs, rt}:
  - (a) id_needs_X and the EX writer rd==id_X.
  - (b) id_needs_X and the MEM writer has memr and rd==id_X.
  - (c) ex_needs_X and the EX writer has memr and rd==id_X (load-use).
  - stall = OR of (a)-(c) over both operands, OR freeze.
- ID forwarding, gated by id_wants_X; nearest stage wins:
  - MEM writer with !memr and rd==id_X -> 01.
  - else WB writer with rd==id_X -> 10.
  - else 00.
- EX forwarding: same rule using the EX entry's rs/rt and its registered wants; 00 when the EX entry is invalid.
- A simultaneous MEM match and WB match on the same register selects MEM.
- Consecutive-stall counter:
  - Increments on each cycle with stall & !freeze; clears on any cycle with !stall.
  - Saturates at STALL_LIMIT; stall_err sets when the count reaches STALL_LIMIT.
  - stall_err clears only on reset.
- Reset (async, any time including mid-stall): all entries invalid, counters 0, stall_err=0. Outputs become stall=0 (freeze permitting) and all fwd=00.
- Latency: stall and forwarding are combinational from current state and ID inputs; tracker updates one cycle later.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined:
  - Adds outputs stall_cnt (SCNT_W) and bubble_cnt (SCNT_W), both saturating, cleared by reset.
  - stall_cnt counts cycles with stall & !freeze.
  - bubble_cnt counts bubbles inserted into EX due to stall.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- add $3 enters EX (regw=1, rd=3); ID is beq $3,$4 with id_needs_rs=1 -> stall=1 for 1 cycle. Next cycle producer in MEM (non-load): stall=0, fwd_id_rs=01.
- lw $5 enters EX; ID is add $6,$5,$1 with ex_needs_rs=1 -> stall=1 one cycle, EX bubble. When add reaches EX, fwd_ex_rs=10 (lw in WB).
- Writer in MEM and writer in WB both rd=7; ID wants rt=7 -> fwd_id_rt=01.
- Writer rd=0 in EX; ID needs rs=0 -> stall=0, fwd_id_rs=00.
- freeze=1 for 4 cycles with lw in EX -> entries unchanged, stall=1. With HAZARD_STATS_EN, stall_cnt unchanged. freeze released -> pipeline resumes from the same state.
- Hold a hazard 15 cycles (by withholding freeze=0 progress through a repeated dependency) -> stall_err=1 at the 15th. Assert rst_n=0 mid-stall -> stall_err=0, all fwd=00, stall=0 immediately.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard scheduler for the 5-stage MIPS core.
//
// Tracks the writers that are in flight in EX/MEM/WB. Each cycle it decides
// whether ID must stall, which inserts a bubble into EX. It also selects the
// forward source for each operand, for consumers in ID and in EX.
//
// Ports
//   clk, rst_n          core clock, async active-low reset
//   freeze              global hold; tracker state holds and stall is forced
//   id_*                ID-stage decoder fields (valid, rs/rt/rdst, regw, memr)
//   id_wants/needs_X    operand read in ID / operand required in ID
//   ex_wants/needs_X    operand read in EX / operand required in EX
//   stall               hold PC and IF/ID, bubble into EX
//   fwd_id_X, fwd_ex_X  00 regfile, 01 MEM ALU result, 10 WB data
//   stall_err           sticky: STALL_LIMIT consecutive stall cycles
//   stall_cnt,
//   bubble_cnt          saturating statistics, present only with HAZARD_STATS_EN
module hazard_ctrl #(
  parameter int STALL_LIMIT = 15,
  parameter int SCNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rdst,
  input  logic              id_regw,
  input  logic              id_memr,
  input  logic              id_wants_rs,
  input  logic              id_needs_rs,
  input  logic              id_wants_rt,
  input  logic              id_needs_rt,
  input  logic              ex_wants_rs,
  input  logic              ex_needs_rs,
  input  logic              ex_wants_rt,
  input  logic              ex_needs_rt,
  output logic              stall,
  output logic [1:0]        fwd_id_rs,
  output logic [1:0]        fwd_id_rt,
  output logic [1:0]        fwd_ex_rs,
  output logic [1:0]        fwd_ex_rt,
`ifdef HAZARD_STATS_EN
  output logic [SCNT_W-1:0] stall_cnt,
  output logic [SCNT_W-1:0] bubble_cnt,
`endif
  output logic              stall_err
);

  localparam int             CW  = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0]  LIM = CW'(STALL_LIMIT);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regw;
    logic       memr;
  } wr_t;

  typedef struct packed {
    wr_t        w;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       wrs;
    logic       wrt;
  } ex_t;

  ex_t           ex_q, ex_d;
  wr_t           mem_q, mem_d, wb_q, wb_d;
  logic [CW-1:0] scnt_q, scnt_d;
  logic          err_q, err_d;
  logic          stall_raw;

  // Register 0 is hard-wired, so an rd of 0 is never a real producer.
  function automatic logic hit(wr_t e, logic [4:0] r);
    return e.valid & e.regw & (e.rd != 5'd0) & (e.rd == r);
  endfunction

  // Nearest stage wins. A load sitting in MEM has no data yet, so it cannot forward.
  function automatic logic [1:0] fsel(logic want, logic [4:0] r, wr_t m, wr_t w);
    if (want && hit(m, r) && !m.memr) return 2'b01;
    if (want && hit(w, r))            return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    logic ex_rs, ex_rt, ld_rs, ld_rt;
    ex_rs = hit(ex_q.w, id_rs);
    ex_rt = hit(ex_q.w, id_rt);
    ld_rs = hit(mem_q, id_rs) & mem_q.memr;
    ld_rt = hit(mem_q, id_rt) & mem_q.memr;
    stall_raw = id_valid & (
        (id_needs_rs & (ex_rs | ld_rs)) |
        (id_needs_rt & (ex_rt | ld_rt)) |
        (ex_needs_rs & ex_rs & ex_q.w.memr) |
        (ex_needs_rt & ex_rt & ex_q.w.memr));
  end

  assign stall     = stall_raw | freeze;
  assign fwd_id_rs = fsel(id_wants_rs, id_rs, mem_q, wb_q);
  assign fwd_id_rt = fsel(id_wants_rt, id_rt, mem_q, wb_q);
  assign fwd_ex_rs = fsel(ex_q.w.valid & ex_q.wrs, ex_q.rs, mem_q, wb_q);
  assign fwd_ex_rt = fsel(ex_q.w.valid & ex_q.wrt, ex_q.rt, mem_q, wb_q);
  assign stall_err = err_q;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!freeze) begin
      wb_d  = mem_q;
      mem_d = ex_q.w;
      ex_d  = '0;
      if (id_valid && !stall) begin
        ex_d.w   = '{valid: 1'b1, rd: id_rdst, regw: id_regw, memr: id_memr};
        ex_d.rs  = id_rs;
        ex_d.rt  = id_rt;
        ex_d.wrs = ex_wants_rs;
        ex_d.wrt = ex_wants_rt;
      end
    end
    // A frozen cycle keeps the count. Only a cycle without any stall clears it.
    scnt_d = scnt_q;
    if (!stall)                        scnt_d = '0;
    else if (!freeze && scnt_q != LIM) scnt_d = scnt_q + 1'b1;
    err_d = err_q | (scnt_d == LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      scnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= mem_d;
      wb_q   <= wb_d;
      scnt_q <= scnt_d;
      err_q  <= err_d;
    end
  end

  // WB.memr is carried for completeness but nothing downstream consumes it.
  logic unused_ok;
  assign unused_ok = &{1'b0, wb_q.memr};

`ifdef HAZARD_STATS_EN
  logic [SCNT_W-1:0] stc_q, stc_d, bub_q, bub_d;
  always_comb begin
    stc_d = stc_q;
    bub_d = bub_q;
    if (stall && !freeze && stc_q != '1)             stc_d = stc_q + 1'b1;
    if (id_valid && stall && !freeze && bub_q != '1) bub_d = bub_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stc_q <= '0;
      bub_q <= '0;
    end else begin
      stc_q <= stc_d;
      bub_q <= bub_d;
    end
  end
  assign stall_cnt  = stc_q;
  assign bubble_cnt = bub_q;
`endif

endmodule
